draw_sequencer: RTL

- Sequences the two pixel engines sharing the VGA framebuffer plot port: the fill engine (screen clear) and the shape engine (e.g. circle drawer).
- On one top-level start it runs fill, then shape, muxes the active engine's pixel stream onto the VGA adapter port, clips off-screen pixels and counts plots.
- Sits between the task top level and the engines; the engines keep the start-held-until-done handshake.

---
 rtl/draw_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs the fill engine then the shape engine on one start,
// muxes the active pixel stream to the VGA port, clips it and counts plots.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   start / done             top-level request, held until done
//   fill_start / fill_done   fill engine handshake
//   fill_x/y/colour/plot     fill engine pixel stream
//   draw_start / draw_done   shape engine handshake
//   draw_x/y/colour/plot     shape engine pixel stream
//   vga_x/y/colour/plot      registered pixel to the VGA adapter
//   plot_count               saturating count of forwarded plots
module draw_sequencer #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter bit CLEAR_FIRST = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  output logic             fill_start,
  input  logic             fill_done,
  input  logic [7:0]       fill_x,
  input  logic [6:0]       fill_y,
  input  logic [2:0]       fill_colour,
  input  logic             fill_plot,
  output logic             draw_start,
  input  logic             draw_done,
  input  logic [7:0]       draw_x,
  input  logic [6:0]       draw_y,
  input  logic [2:0]       draw_colour,
  input  logic             draw_plot,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic [CNT_W-1:0] plot_count
);

  localparam logic [31:0] W_LIM = SCREEN_W;
  localparam logic [31:0] H_LIM = SCREEN_H;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_GAP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic             src_take;
  logic [7:0]       src_x;
  logic [6:0]       src_y;
  logic [2:0]       src_c;
  logic             src_plot;
  logic             src_vis;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Dropping start anywhere but IDLE abandons the
  // sequence; it takes priority over engine done.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = CLEAR_FIRST ? S_FILL : S_DRAW;
        end
      end
      S_FILL: begin
        if (!start) begin
          state_n = S_IDLE;
        end else if (fill_done) begin
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        state_n = start ? S_DRAW : S_IDLE;
      end
      S_DRAW: begin
        if (!start) begin
          state_n = S_IDLE;
        end else if (draw_done) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The source is chosen by the state held during the
  // sampling cycle, so the pixel presented alongside an
  // engine's done is still forwarded.
  always_comb begin
    src_take = 1'b0;
    src_x    = '0;
    src_y    = '0;
    src_c    = '0;
    src_plot = 1'b0;
    unique case (1'b1)
      (state == S_FILL): begin
        src_take = 1'b1;
        src_x    = fill_x;
        src_y    = fill_y;
        src_c    = fill_colour;
        src_plot = fill_plot;
      end
      (state == S_DRAW): begin
        src_take = 1'b1;
        src_x    = draw_x;
        src_y    = draw_y;
        src_c    = draw_colour;
        src_plot = draw_plot;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    src_vis = src_plot
            & ({24'd0, src_x} < W_LIM)
            & ({25'd0, src_y} < H_LIM);
  end

  // Count tracks vga_plot on the same edge, so done and
  // the final count appear together.
  always_comb begin
    cnt_clr = (state == S_IDLE) & start;
    cnt_n   = plot_count;
    if (cnt_clr) begin
      cnt_n = '0;
    end else if (src_vis && !(&plot_count)) begin
      cnt_n = plot_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done       <= 1'b0;
      fill_start <= 1'b0;
      draw_start <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      plot_count <= '0;
    end else begin
      done       <= (state_n == S_DONE);
      fill_start <= (state_n == S_FILL);
      draw_start <= (state_n == S_DRAW);
      vga_plot   <= src_vis;
      if (src_take) begin
        vga_x      <= src_x;
        vga_y      <= src_y;
        vga_colour <= src_c;
      end
      plot_count <= cnt_n;
    end
  end

endmodule
